// File: rtl/urng_taus88_pkg.sv
// Shared constants and FSM state type for the Tausworthe-88 uniform RNG.
// Shift triples, component masks and minimum legal seeds.
package urng_pkg;

  localparam logic [31:0] Mask1 = 32'hFFFF_FFFE;
  localparam logic [31:0] Mask2 = 32'hFFFF_FFF8;
  localparam logic [31:0] Mask3 = 32'hFFFF_FFF0;

  localparam int unsigned S1ShA = 13;
  localparam int unsigned S1ShB = 19;
  localparam int unsigned S1ShC = 12;
  localparam int unsigned S2ShA = 2;
  localparam int unsigned S2ShB = 25;
  localparam int unsigned S2ShC = 4;
  localparam int unsigned S3ShA = 3;
  localparam int unsigned S3ShB = 11;
  localparam int unsigned S3ShC = 17;

  // Smallest legal state per component; also the OR-mask used by the seed fixup.
  localparam logic [31:0] MinS1 = 32'd2;
  localparam logic [31:0] MinS2 = 32'd8;
  localparam logic [31:0] MinS3 = 32'd16;

  typedef enum logic [1:0] {
    StRun,
    StL2,
    StL3
  } state_e;

endpackage

// File: rtl/urng_taus88_if.sv
// Seed-load and output-stream handshake bundle for urng_taus88.
// slave is the generator side, master is the environment side.
interface urng_taus88_if;
  logic        seed_valid;
  logic        seed_ready;
  logic [31:0] seed_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  modport master (
    output seed_valid,
    output seed_data,
    output out_ready,
    input  seed_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  modport slave (
    input  seed_valid,
    input  seed_data,
    input  out_ready,
    output seed_ready,
    output out_valid,
    output out_data,
    output busy
  );
endinterface

// File: rtl/urng_taus88_step.sv
// One combinational Tausworthe-88 step: (s1,s2,s3) -> (s1',s2',s3', s1'^s2'^s3').
// All arithmetic is 32-bit with truncation.
module urng_taus88_step
  import urng_pkg::*;
(
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  input  logic [31:0] s3,
  output logic [31:0] s1_next,
  output logic [31:0] s2_next,
  output logic [31:0] s3_next,
  output logic [31:0] word
);

  logic [31:0] b1, b2, b3;

  always_comb begin
    b1      = ((s1 << S1ShA) ^ s1) >> S1ShB;
    s1_next = ((s1 & Mask1) << S1ShC) ^ b1;
    b2      = ((s2 << S2ShA) ^ s2) >> S2ShB;
    s2_next = ((s2 & Mask2) << S2ShC) ^ b2;
    b3      = ((s3 << S3ShA) ^ s3) >> S3ShB;
    s3_next = ((s3 & Mask3) << S3ShC) ^ b3;
    word    = s1_next ^ s2_next ^ s3_next;
  end

endmodule

// File: rtl/urng_taus88.sv
// Tausworthe-88 URNG with valid/ready output and 3-beat runtime reseed.
// Define URNG_SEED_FIXUP_EN to force captured seed words into the legal range.
module urng_taus88
  import urng_pkg::*;
#(
  parameter logic [31:0] DEFAULT_S1 = 32'd12345,
  parameter logic [31:0] DEFAULT_S2 = 32'd12345,
  parameter logic [31:0] DEFAULT_S3 = 32'd12345
) (
  input  logic         clk,
  input  logic         rst_n,
  urng_taus88_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic [31:0] s1_next, s2_next, s3_next, word;
  logic [31:0] seed1, seed2, seed3;

`ifdef URNG_SEED_FIXUP_EN
  assign seed1 = bus.seed_data | MinS1;
  assign seed2 = bus.seed_data | MinS2;
  assign seed3 = bus.seed_data | MinS3;
`else
  assign seed1 = bus.seed_data;
  assign seed2 = bus.seed_data;
  assign seed3 = bus.seed_data;
`endif

  urng_taus88_step u_step (
    .s1      (s1_q),
    .s2      (s2_q),
    .s3      (s3_q),
    .s1_next (s1_next),
    .s2_next (s2_next),
    .s3_next (s3_next),
    .word    (word)
  );

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StRun: begin
        // A seed beat takes priority; any concurrent out handshake still completes.
        if (bus.seed_valid) begin
          s1_d        = seed1;
          out_valid_d = 1'b0;
          state_d     = StL2;
        end else if (!out_valid_q || bus.out_ready) begin
          s1_d        = s1_next;
          s2_d        = s2_next;
          s3_d        = s3_next;
          out_data_d  = word;
          out_valid_d = 1'b1;
        end
      end
      StL2: begin
        out_valid_d = 1'b0;
        if (bus.seed_valid) begin
          s2_d    = seed2;
          state_d = StL3;
        end
      end
      StL3: begin
        out_valid_d = 1'b0;
        if (bus.seed_valid) begin
          s3_d    = seed3;
          state_d = StRun;
        end
      end
      default: begin
        state_d     = StRun;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      s1_q        <= DEFAULT_S1;
      s2_q        <= DEFAULT_S2;
      s3_q        <= DEFAULT_S3;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.seed_ready = 1'b1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = (state_q != StRun);

endmodule

// File: doc/urng_taus88.md
Name: urng_taus88

Overview:
- 32-bit uniform random number generator using the Tausworthe-88 combined generator (three component LFSRs).
- Sits directly upstream of e_x_preprocess. Its out_data drives the x input of e_x_preprocess.
- Supports runtime reseeding through a 3-beat seed handshake.
- Delivers one word per accepted out transfer, using valid/ready flow control.

Parameters:
- DEFAULT_S1, 32'd12345: component-1 state after reset; must be > 1.
- DEFAULT_S2, 32'd12345: component-2 state after reset; must be > 7.
- DEFAULT_S3, 32'd12345: component-3 state after reset; must be > 15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- seed_valid  in  1  seed beat present on seed_data.
- seed_ready  out  1  seed beat acceptance; constant 1 (accepted every cycle).
- seed_data  in  32  seed word; beats arrive in order s1, s2, s3.
- out_valid  out  1  out_data holds an unconsumed random word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  32  uniform random word s1^s2^s3.
- busy  out  1  high while a seed load is in progress (states L2, L3).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - s1/s2/s3 take DEFAULT_S1/S2/S3.
  - out_data=0, out_valid=0, busy=0, state=RUN.
- Step function, all 32-bit with truncation:
  - b=((s1<<13)^s1)>>19; s1'=((s1&FFFFFFFE)<<12)^b
  - b=((s2<<2)^s2)>>25; s2'=((s2&FFFFFFF8)<<4)^b
  - b=((s3<<3)^s3)>>11; s3'=((s3&FFFFFFF0)<<17)^b
  - word = s1'^s2'^s3'.
- FSM states: RUN, L2, L3.
- RUN, no seed beat: if out_valid=0, or out_valid&out_ready:
  - s* <= s*'; out_data <= word; out_valid <= 1.
  - Otherwise hold everything, so out_data stays stable while stalled.
- First valid word appears on the first rising edge after rst_n deasserts. Latency is 1 cycle per word; sustained throughput is 1 word/cycle with out_ready held high.
- RUN, seed beat (seed_valid=1):
  - s1 <= seed_data; out_valid <= 0; -> L2.
  - Priority: the seed beat wins over an output step. A simultaneous out handshake still counts as a completed transfer of the current word.
- L2:
  - out_valid=0, busy=1.
  - Seed beat: s2 <= seed_data; -> L3. No beat: hold.
- L3:
  - out_valid=0, busy=1.
  - Seed beat: s3 <= seed_data; -> RUN. out_valid stays 0 this cycle.
  - First post-seed word appears on the next edge.
- No timeout in L2/L3: the FSM waits indefinitely for the remaining beats.
- Reset mid-load: abandons the load; states return to the DEFAULT_* values.
- out_ready is ignored while out_valid=0.

Optional Feature:
- Macro URNG_SEED_FIXUP_EN.
- Defined: captured seed words are forced legal.
  - s1 <= seed|32'h2, s2 <= seed|32'h8, s3 <= seed|32'h10.
- Undefined: seeds are stored verbatim. Illegal seeds (e.g. all-zero) yield a degenerate stream. For all-zero seeds every output is 0.
- DEFAULT_* parameters are never modified by the fixup.

Decomposition:
- Package urng_pkg holds:
  - masks FFFFFFFE/FFFFFFF8/FFFFFFF0;
  - shift constants (13,19,12 / 2,25,4 / 3,11,17);
  - minimum-seed constants 2/8/16;
  - FSM state enum RUN/L2/L3.
- One sub-module, urng_taus88_step:
  - purely combinational;
  - maps (s1,s2,s3) to (s1',s2',s3',word);
  - reused by the bench reference model.

Test Plan:
- Reset, then seed beats 2, 8, 16 with out_ready=1 -> first words 32'h00202080, then 32'h02002C80.
- Same seed; hold out_ready=0 for 5 cycles after out_valid rises -> out_data stays 32'h00202080 and no step occurs. Release -> next word is 32'h02002C80.
- Free-run from default seeds with out_ready=1 for 1000 cycles -> every word matches the urng_taus88_step model; out_valid stays high continuously.
- Seed beat in RUN together with out_valid&out_ready, then 5 idle cycles before beats 2 and 3:
  - out_valid=0 and busy=1 throughout;
  - after the third beat the stream restarts from the new seed.
- rst_n pulsed low while in L3 -> out_valid=0 and busy=0 immediately; the next stream equals the default-seed stream.
- All-zero seed load:
  - with URNG_SEED_FIXUP_EN defined -> output equals the seed (2,8,16) stream (32'h00202080 first);
  - without the macro -> out_data=0 for every word.
